// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Purpose  : Core-side store/load handshake and data-memory port bundle
//            for the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
  parameter int AW = 16
);
  // Core store channel
  logic          StoreValid;
  logic [AW-1:0] StoreAddr;
  logic [15:0]   StoreData;
  logic          StoreReady;
  // Core load channel
  logic          LoadValid;
  logic [AW-1:0] LoadAddr;
  logic [15:0]   LoadData;
  logic          LoadStall;
  // Data-memory port
  logic [AW-1:0] MemAddress;
  logic [15:0]   MemWriteData;
  logic          MemWrite;
  logic          MemRead;
  logic [15:0]   MemReadData;
  // Status
  logic          Empty;

  // Core and memory model side
  modport master (
    output StoreValid, StoreAddr, StoreData, LoadValid, LoadAddr, MemReadData,
    input  StoreReady, LoadData, LoadStall, MemAddress, MemWriteData,
           MemWrite, MemRead, Empty
  );

  // Store buffer side
  modport slave (
    input  StoreValid, StoreAddr, StoreData, LoadValid, LoadAddr, MemReadData,
    output StoreReady, LoadData, LoadStall, MemAddress, MemWriteData,
           MemWrite, MemRead, Empty
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Circular store buffer with load forwarding. Halfword stores are
//            queued and drained to data memory in order; loads that miss the
//            buffer take the memory port first, exact matches are forwarded
//            from the youngest entry, and partial overlaps stall the load
//            until the overlapping entry has drained.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  wire logic     Clock,
  input  wire logic     ResetN,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [15:0]   r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic          w_store_acc;
  logic          w_partial;
  logic          w_full;
  logic [15:0]   w_fwd_data;
  logic [PW-1:0] w_idx;
  logic [AW-1:0] w_load_p1;
  logic          w_stall;
  logic          w_fwd;
  logic          w_miss;
  logic          w_drain;

  assign w_load_p1 = bus.LoadAddr + AW'(1);

  // Scan valid entries oldest to youngest; the last full match wins, so the
  // forwarded data is always the youngest store to that address.
  always_comb begin
    w_partial  = 1'b0;
    w_full     = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if (i < int'(r_count)) begin
        if (r_addr[w_idx] == bus.LoadAddr) begin
          w_full     = 1'b1;
          w_fwd_data = r_data[w_idx];
        end
        if ((r_addr[w_idx] == w_load_p1) ||
            ((r_addr[w_idx] + AW'(1)) == bus.LoadAddr)) begin
          w_partial = 1'b1;
        end
      end
    end
  end

  // A partial overlap outranks a full match: the load cannot be assembled
  // from one entry, so it waits until the overlapping stores reach memory.
  assign w_stall     = ResetN && bus.LoadValid && w_partial;
  assign w_fwd       = ResetN && bus.LoadValid && !w_partial && w_full;
  assign w_miss      = ResetN && bus.LoadValid && !w_partial && !w_full;
  assign w_drain     = ResetN && (r_count != '0) && !w_miss;
  assign w_store_acc = bus.StoreValid && bus.StoreReady;

  assign bus.StoreReady = ResetN && (r_count < (PW+1)'(DEPTH));
  assign bus.LoadStall  = w_stall;
  assign bus.Empty      = !ResetN || (r_count == '0);

  // Memory port arbitration: a missing load owns the port, otherwise the head
  // entry drains; forwarded data rides alongside a drain.
  always_comb begin
    bus.MemAddress   = '0;
    bus.MemWriteData = '0;
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.LoadData     = '0;
    if (w_miss) begin
      bus.MemAddress = bus.LoadAddr;
      bus.MemRead    = 1'b1;
      bus.LoadData   = bus.MemReadData;
    end else if (w_drain) begin
      bus.MemAddress   = r_addr[r_rd_ptr];
      bus.MemWriteData = r_data[r_rd_ptr];
      bus.MemWrite     = 1'b1;
    end
    if (w_fwd) begin
      bus.LoadData = w_fwd_data;
    end
  end

  // Pointer and occupancy update; reset discards all buffered stores.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_store_acc, w_drain})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are meaningful only while covered by r_count.
  always_ff @(posedge Clock) begin
    if (w_store_acc) begin
      r_addr[r_wr_ptr] <= bus.StoreAddr;
      r_data[r_wr_ptr] <= bus.StoreData;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer. Accepted stores are queued
//            as expected memory writes and compared in order against every
//            MemWrite the buffer issues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int AW = 16;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  always #5 Clock = ~Clock;

  store_buffer_if #(.AW(AW)) sb ();

  store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (sb)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_exp;

  // Scoreboard: record accepted stores, compare drained writes in order,
  // forget everything on reset.
  always @(negedge Clock) begin
    if (!ResetN) begin
      exp_q.delete();
    end else begin
      if (sb.MemWrite) begin
        n_writes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_unexpected: got write %h/%h, required no write",
                   sb.MemAddress, sb.MemWriteData);
        end else begin
          m_exp = exp_q.pop_front();
          if ({sb.MemAddress, sb.MemWriteData} !== m_exp) begin
            n_fail++;
            $display("FAIL drain_order: got %h/%h, required %h/%h",
                     sb.MemAddress, sb.MemWriteData, m_exp[31:16], m_exp[15:0]);
          end
        end
      end
      if (sb.StoreValid && sb.StoreReady) begin
        exp_q.push_back({sb.StoreAddr, sb.StoreData});
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    sb.StoreValid  = 1'b0;
    sb.StoreAddr   = '0;
    sb.StoreData   = '0;
    sb.LoadValid   = 1'b0;
    sb.LoadAddr    = '0;
    sb.MemReadData = '0;
  endtask

  task automatic drive_store(input logic [15:0] a, input logic [15:0] d);
    sb.StoreValid = 1'b1;
    sb.StoreAddr  = a;
    sb.StoreData  = d;
  endtask

  task automatic wait_empty(input string tag);
    tick();
    sb.StoreValid = 1'b0;
    sb.LoadValid  = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clock);
      if (sb.Empty === 1'b1) break;
    end
    n_checks++;
    if (sb.Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: Empty=%b required 1", tag, sb.Empty);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_lost_stores: %0d pending, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ResetN = 1'b0;
    tick();
    drive_store(16'h1234, 16'h5678);
    sb.LoadValid   = 1'b1;
    sb.LoadAddr    = 16'h0055;
    sb.MemReadData = 16'hFFFF;
    @(negedge Clock);
    n_checks++;
    if ({sb.StoreReady, sb.MemWrite, sb.MemRead, sb.LoadStall, sb.Empty} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/wr/rd/stall/empty=%b, required 00001",
               {sb.StoreReady, sb.MemWrite, sb.MemRead, sb.LoadStall, sb.Empty});
    end
    n_checks++;
    if ({sb.LoadData, sb.MemAddress, sb.MemWriteData} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h, required 0/0/0",
               sb.LoadData, sb.MemAddress, sb.MemWriteData);
    end
    tick();
    ResetN = 1'b1;
    idle_inputs();
    @(negedge Clock);
    n_checks++;
    if ({sb.StoreReady, sb.Empty, sb.MemWrite, sb.MemRead} !== 4'b1100) begin
      n_fail++;
      $display("FAIL post_reset: got rdy/empty/wr/rd=%b, required 1100",
               {sb.StoreReady, sb.Empty, sb.MemWrite, sb.MemRead});
    end
    n_checks++;
    if ({sb.LoadData, sb.MemAddress, sb.MemWriteData} !== 48'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h/%h/%h, required 0/0/0",
               sb.LoadData, sb.MemAddress, sb.MemWriteData);
    end
  endtask

  task automatic test_single_store();
    tick();
    drive_store(16'h0010, 16'hBEEF);
    @(negedge Clock);
    n_checks++;
    if ({sb.StoreReady, sb.MemWrite, sb.Empty} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_cycle0: got rdy/wr/empty=%b, required 101",
               {sb.StoreReady, sb.MemWrite, sb.Empty});
    end
    tick();
    sb.StoreValid = 1'b0;
    @(negedge Clock);
    n_checks++;
    if ({sb.MemWrite, sb.MemAddress, sb.MemWriteData} !== {1'b1, 16'h0010, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL single_cycle1: got wr=%b %h/%h, required 1 0010/beef",
               sb.MemWrite, sb.MemAddress, sb.MemWriteData);
    end
    tick();
    @(negedge Clock);
    n_checks++;
    if ({sb.Empty, sb.MemWrite} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_cycle2: got empty/wr=%b, required 10", {sb.Empty, sb.MemWrite});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      tick();
      sb.LoadValid   = 1'b1;
      sb.LoadAddr    = 16'h0070;
      sb.MemReadData = 16'h5A5A;
      drive_store(16'h0040 + 16'(2 * i), 16'hA000 + 16'(i));
      @(negedge Clock);
      n_checks++;
      if ({sb.StoreReady, sb.MemRead, sb.MemWrite, sb.LoadStall, sb.LoadData, sb.MemAddress}
          !== {4'b1100, 16'h5A5A, 16'h0070}) begin
        n_fail++;
        $display("FAIL fill_store%0d: got rdy/rd/wr/stall=%b data=%h addr=%h, required 1100 5a5a 0070",
                 i, {sb.StoreReady, sb.MemRead, sb.MemWrite, sb.LoadStall}, sb.LoadData, sb.MemAddress);
      end
    end
    tick();
    drive_store(16'h0048, 16'hA004);
    @(negedge Clock);
    n_checks++;
    if ({sb.StoreReady, sb.MemWrite} !== 2'b00) begin
      n_fail++;
      $display("FAIL fill_full: got rdy/wr=%b, required 00", {sb.StoreReady, sb.MemWrite});
    end
    tick();
    sb.LoadValid = 1'b0;
    @(negedge Clock);
    n_checks++;
    if ({sb.StoreReady, sb.MemWrite, sb.MemAddress} !== {2'b01, 16'h0040}) begin
      n_fail++;
      $display("FAIL fill_first_drain: got rdy/wr=%b addr=%h, required 01 0040",
               {sb.StoreReady, sb.MemWrite}, sb.MemAddress);
    end
    tick();
    @(negedge Clock);
    n_checks++;
    if (sb.StoreReady !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_ready_again: got %b, required 1", sb.StoreReady);
    end
    wait_empty("fill");
  endtask

  task automatic test_forward();
    tick();
    sb.LoadValid   = 1'b1;
    sb.LoadAddr    = 16'h0070;
    sb.MemReadData = 16'hDEAD;
    drive_store(16'h0020, 16'h1111);
    tick();
    drive_store(16'h0020, 16'h2222);
    tick();
    sb.StoreValid = 1'b0;
    sb.LoadAddr   = 16'h0020;
    @(negedge Clock);
    n_checks++;
    if ({sb.LoadStall, sb.MemRead, sb.MemWrite, sb.LoadData} !== {3'b001, 16'h2222}) begin
      n_fail++;
      $display("FAIL forward_youngest: got stall/rd/wr=%b data=%h, required 001 2222",
               {sb.LoadStall, sb.MemRead, sb.MemWrite}, sb.LoadData);
    end
    tick();
    @(negedge Clock);
    n_checks++;
    if ({sb.LoadStall, sb.MemRead, sb.LoadData} !== {2'b00, 16'h2222}) begin
      n_fail++;
      $display("FAIL forward_remaining: got stall/rd=%b data=%h, required 00 2222",
               {sb.LoadStall, sb.MemRead}, sb.LoadData);
    end
    wait_empty("forward");
    // A store accepted alongside a load is invisible to that load.
    tick();
    sb.LoadValid   = 1'b1;
    sb.LoadAddr    = 16'h0090;
    sb.MemReadData = 16'h0BAD;
    drive_store(16'h0090, 16'h9999);
    @(negedge Clock);
    n_checks++;
    if ({sb.LoadStall, sb.MemRead, sb.LoadData} !== {2'b01, 16'h0BAD}) begin
      n_fail++;
      $display("FAIL same_cycle_load: got stall/rd=%b data=%h, required 01 0bad",
               {sb.LoadStall, sb.MemRead}, sb.LoadData);
    end
    tick();
    sb.StoreValid = 1'b0;
    @(negedge Clock);
    n_checks++;
    if ({sb.MemRead, sb.LoadData} !== {1'b0, 16'h9999}) begin
      n_fail++;
      $display("FAIL next_cycle_fwd: got rd=%b data=%h, required 0 9999", sb.MemRead, sb.LoadData);
    end
    wait_empty("same_cycle");
  endtask

  task automatic test_partial();
    tick();
    sb.LoadValid   = 1'b1;
    sb.LoadAddr    = 16'h0070;
    sb.MemReadData = 16'h7777;
    drive_store(16'h0030, 16'h3333);
    tick();
    drive_store(16'h0050, 16'h5555);
    tick();
    sb.StoreValid = 1'b0;
    sb.LoadAddr   = 16'h0031;
    @(negedge Clock);
    n_checks++;
    if ({sb.LoadStall, sb.MemRead, sb.MemWrite, sb.LoadData, sb.MemAddress}
        !== {3'b101, 16'h0000, 16'h0030}) begin
      n_fail++;
      $display("FAIL partial_stall: got stall/rd/wr=%b data=%h addr=%h, required 101 0000 0030",
               {sb.LoadStall, sb.MemRead, sb.MemWrite}, sb.LoadData, sb.MemAddress);
    end
    tick();
    @(negedge Clock);
    n_checks++;
    if ({sb.LoadStall, sb.MemRead, sb.MemWrite, sb.LoadData, sb.MemAddress}
        !== {3'b010, 16'h7777, 16'h0031}) begin
      n_fail++;
      $display("FAIL partial_release: got stall/rd/wr=%b data=%h addr=%h, required 010 7777 0031",
               {sb.LoadStall, sb.MemRead, sb.MemWrite}, sb.LoadData, sb.MemAddress);
    end
    tick();
    sb.LoadAddr = 16'h004F;
    @(negedge Clock);
    n_checks++;
    if ({sb.LoadStall, sb.MemRead, sb.MemWrite} !== 3'b101) begin
      n_fail++;
      $display("FAIL partial_below: got stall/rd/wr=%b, required 101",
               {sb.LoadStall, sb.MemRead, sb.MemWrite});
    end
    wait_empty("partial");
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      tick();
      sb.LoadValid = 1'b0;
      drive_store(16'h0100 + 16'(2 * i), 16'hC000 + 16'(i));
      @(negedge Clock);
      n_checks++;
      if (sb.StoreReady !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_ready%0d: got %b, required 1", i, sb.StoreReady);
      end
    end
    wait_empty("wrap");
    n_checks++;
    if (n_writes - w0 != 10) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes, required 10", n_writes - w0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      tick();
      sb.LoadValid = 1'b1;
      sb.LoadAddr  = 16'h0070;
      drive_store(16'h0200 + 16'(2 * i), 16'hD000 + 16'(i));
    end
    tick();
    idle_inputs();
    ResetN = 1'b0;
    @(negedge Clock);
    n_checks++;
    if ({sb.MemWrite, sb.Empty, sb.StoreReady} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_mid: got wr/empty/rdy=%b, required 010",
               {sb.MemWrite, sb.Empty, sb.StoreReady});
    end
    tick();
    ResetN = 1'b1;
    @(negedge Clock);
    n_checks++;
    if ({sb.MemWrite, sb.Empty, sb.StoreReady} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_release: got wr/empty/rdy=%b, required 011",
               {sb.MemWrite, sb.Empty, sb.StoreReady});
    end
    tick();
    @(negedge Clock);
    n_checks++;
    if (sb.MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_write: got %b, required 0", sb.MemWrite);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_forward();
    test_partial();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
